bip_core: RTL and testbench

Parametrised Basic Instruction Processor core: a single-accumulator CPU with configurable data, operand and PC widths, an internal data memory and an external combinational instruction-memory port. It succeeds the fixed 16-bit BIP top level and adds a halt flag, a retired-instruction counter and optional branch instructions. It sits under the board-level top, which supplies the program ROM.

---
 rtl/bip_pkg.sv | 26 ++
 rtl/bip_dmem.sv | 23 ++
 rtl/bip_core.sv | 122 ++++++++++++
 tb/tb_bip_core.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/bip_pkg.sv
// Shared definitions for the parametrised Basic Instruction Processor core:
// opcode encodings, FSM state type and fixed field widths.
package bip_pkg;

  localparam int unsigned OPCODE_WIDTH  = 5;
  localparam int unsigned RETIRED_WIDTH = 16;

  localparam logic [OPCODE_WIDTH-1:0] OP_HLT  = 5'b00000;
  localparam logic [OPCODE_WIDTH-1:0] OP_STO  = 5'b00001;
  localparam logic [OPCODE_WIDTH-1:0] OP_LD   = 5'b00010;
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = 5'b00011;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = 5'b00100;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = 5'b00101;
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = 5'b00110;
  localparam logic [OPCODE_WIDTH-1:0] OP_SUBI = 5'b00111;
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ  = 5'b01000;
  localparam logic [OPCODE_WIDTH-1:0] OP_BNE  = 5'b01001;
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = 5'b01010;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

endpackage

// File: rtl/bip_dmem.sv
// Single-port data RAM: synchronous write, asynchronous read.
module bip_dmem #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata_c
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata_c = mem[addr];

endmodule

// File: rtl/bip_core.sv
// Single-accumulator BIP core with halt flag and saturating retired counter.
// Branch opcodes (BEQ/BNE/JMP) exist only when BIP_BRANCH_EN is defined.
module bip_core
  import bip_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned OPERAND_WIDTH   = 11,
  parameter int unsigned PC_WIDTH        = 11,
  parameter int unsigned DMEM_ADDR_WIDTH = 10
) (
  input  logic                                   clk,
  input  logic                                   reset,
  output logic [PC_WIDTH-1:0]                    imem_addr,
  input  logic [OPCODE_WIDTH+OPERAND_WIDTH-1:0]  imem_data,
  output logic [DATA_WIDTH-1:0]                  acc,
  output logic [PC_WIDTH-1:0]                    pc,
  output logic                                   halted,
  output logic [RETIRED_WIDTH-1:0]               retired
);

  localparam int unsigned INSTR_WIDTH = OPCODE_WIDTH + OPERAND_WIDTH;
  localparam logic [RETIRED_WIDTH-1:0] RETIRED_MAX = '1;

  state_t                   state, state_next;
  logic [INSTR_WIDTH-1:0]   ir, ir_next;
  logic [DATA_WIDTH-1:0]    acc_next;
  logic [PC_WIDTH-1:0]      pc_next;
  logic                     halted_next;
  logic [RETIRED_WIDTH-1:0] retired_next;
  logic                     dmem_we_c;

  logic [OPCODE_WIDTH-1:0]  opcode;
  logic [OPERAND_WIDTH-1:0] operand;
  logic [DATA_WIDTH-1:0]    imm;
  logic [DATA_WIDTH-1:0]    mem_rdata_c;
  logic [PC_WIDTH-1:0]      pc_inc;
  logic                     unused_operand;

  assign opcode         = ir[INSTR_WIDTH-1 -: OPCODE_WIDTH];
  assign operand        = ir[OPERAND_WIDTH-1:0];
  // Signed size cast sign-extends when widening and truncates when narrowing.
  assign imm            = DATA_WIDTH'($signed(operand));
  assign pc_inc         = pc + PC_WIDTH'(1);
  assign imem_addr      = pc;
  assign unused_operand = ^operand;

  bip_dmem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (DMEM_ADDR_WIDTH)
  ) u_dmem (
    .clk     (clk),
    .we      (dmem_we_c && !reset),
    .addr    (operand[DMEM_ADDR_WIDTH-1:0]),
    .wdata   (acc),
    .rdata_c (mem_rdata_c)
  );

  // State and architectural registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_FETCH;
      ir      <= '0;
      acc     <= '0;
      pc      <= '0;
      halted  <= 1'b0;
      retired <= '0;
    end else begin
      state   <= state_next;
      ir      <= ir_next;
      acc     <= acc_next;
      pc      <= pc_next;
      halted  <= halted_next;
      retired <= retired_next;
    end
  end

  // Next-state decode and instruction execution.
  always_comb begin
    state_next   = state;
    ir_next      = ir;
    acc_next     = acc;
    pc_next      = pc;
    halted_next  = halted;
    retired_next = retired;
    dmem_we_c    = 1'b0;

    case (state)
      ST_FETCH: begin
        ir_next    = imem_data;
        state_next = ST_EXEC;
      end
      ST_EXEC: begin
        state_next = ST_FETCH;
        pc_next    = pc_inc;
        if (retired != RETIRED_MAX) retired_next = retired + RETIRED_WIDTH'(1);
        case (opcode)
          OP_HLT: begin
            pc_next     = pc;
            state_next  = ST_HALT;
            halted_next = 1'b1;
          end
          OP_STO:  dmem_we_c = 1'b1;
          OP_LD:   acc_next  = mem_rdata_c;
          OP_LDI:  acc_next  = imm;
          OP_ADD:  acc_next  = acc + mem_rdata_c;
          OP_ADDI: acc_next  = acc + imm;
          OP_SUB:  acc_next  = acc - mem_rdata_c;
          OP_SUBI: acc_next  = acc - imm;
`ifdef BIP_BRANCH_EN
          OP_BEQ:  if (acc == '0) pc_next = operand[PC_WIDTH-1:0];
          OP_BNE:  if (acc != '0) pc_next = operand[PC_WIDTH-1:0];
          OP_JMP:  pc_next = operand[PC_WIDTH-1:0];
`endif
          default: ;
        endcase
      end
      ST_HALT: ;
      default: state_next = ST_FETCH;
    endcase
  end

endmodule

// File: tb/tb_bip_core.sv
// Directed self-checking bench for bip_core with a combinational program ROM.
// Branch expectations follow BIP_BRANCH_EN.
module tb_bip_core;
  import bip_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] acc;
  logic [10:0] pc;
  logic        halted;
  logic [15:0] retired;

  logic [15:0] rom [2048];
  int          wp;
  int          errors = 0;
  int          checks = 0;

  localparam logic [4:0] OP_NOP = 5'b11111;

  assign imem_data = rom[imem_addr];

  always #5 clk = ~clk;

  bip_core dut (
    .clk       (clk),
    .reset     (reset),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .acc       (acc),
    .pc        (pc),
    .halted    (halted),
    .retired   (retired)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic prog_clear(input logic [15:0] fill);
    for (int i = 0; i < 2048; i++) rom[i] = fill;
    wp = 0;
  endtask

  task automatic emit(input logic [4:0] op, input logic [10:0] opd);
    rom[wp] = {op, opd};
    wp++;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold reset for two edges, then release at a falling edge so the next
  // rising edge is the end of the first FETCH.
  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    step(2);
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic run_to_halt(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (halted !== 1'b1 && n < max_cycles) begin
      step(1);
      n++;
    end
    check(tag, 32'(halted), 32'd1);
  endtask

  initial begin
    // Program 1: LDI 5, ADDI 3, SUBI 1, HLT
    prog_clear({OP_HLT, 11'd0});
    emit(OP_LDI, 11'd5);
    emit(OP_ADDI, 11'd3);
    emit(OP_SUBI, 11'd1);
    emit(OP_HLT, 11'd0);
    @(negedge clk) reset = 1'b1;
    step(2);
    check("rst_acc", 32'(acc), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    @(negedge clk) reset = 1'b0;
    step(2);
    check("p1_ldi", 32'(acc), 32'h0005);
    check("p1_pc1", 32'(pc), 32'd1);
    step(2);
    check("p1_addi", 32'(acc), 32'h0008);
    step(2);
    check("p1_subi", 32'(acc), 32'h0007);
    step(1);
    check("p1_not_halted_in_exec", 32'(halted), 32'd0);
    step(1);
    check("p1_halted_cycle8", 32'(halted), 32'd1);
    check("p1_pc", 32'(pc), 32'd3);
    check("p1_retired", 32'(retired), 32'd4);
    step(4);
    check("p1_hold_pc", 32'(pc), 32'd3);
    check("p1_hold_acc", 32'(acc), 32'h0007);
    check("p1_hold_retired", 32'(retired), 32'd4);

    // Program 2: sign extension and wrap
    prog_clear({OP_HLT, 11'd0});
    emit(OP_LDI, 11'h7FF);
    emit(OP_ADDI, 11'd1);
    emit(OP_LDI, 11'h3FF);
    emit(OP_SUBI, 11'h400);
    emit(OP_HLT, 11'd0);
    do_reset();
    step(2);
    check("p2_ldi_neg1", 32'(acc), 32'hFFFF);
    step(2);
    check("p2_wrap", 32'(acc), 32'h0000);
    step(2);
    check("p2_ldi_maxpos", 32'(acc), 32'h03FF);
    step(2);
    check("p2_subi_minneg", 32'(acc), 32'h07FF);
    run_to_halt("p2_halt", 20);
    check("p2_retired", 32'(retired), 32'd5);

    // Program 3: memory store/load/add/sub
    prog_clear({OP_HLT, 11'd0});
    emit(OP_LDI, 11'd1);
    emit(OP_STO, 11'd5);
    emit(OP_LDI, 11'd42);
    emit(OP_STO, 11'd7);
    emit(OP_LDI, 11'd0);
    emit(OP_ADD, 11'd7);
    emit(OP_ADD, 11'd7);
    emit(OP_SUBI, 11'd1);
    emit(OP_STO, 11'd5);
    emit(OP_LD, 11'd5);
    emit(OP_SUB, 11'd7);
    emit(OP_ADD, 11'h407);
    emit(OP_HLT, 11'd0);
    do_reset();
    step(14);
    check("p3_add_twice", 32'(acc), 32'd84);
    step(6);
    check("p3_sto_then_ld", 32'(acc), 32'd83);
    step(2);
    check("p3_sub_mem", 32'(acc), 32'd41);
    step(2);
    check("p3_addr_high_ignored", 32'(acc), 32'd83);
    run_to_halt("p3_halt", 20);
    check("p3_retired", 32'(retired), 32'd13);
    check("p3_pc", 32'(pc), 32'd12);

    // Program 4: countdown loop using BNE
    prog_clear({OP_HLT, 11'd0});
    emit(OP_LDI, 11'd3);
    emit(OP_SUBI, 11'd1);
    emit(OP_BNE, 11'd1);
    emit(OP_HLT, 11'd0);
    do_reset();
    run_to_halt("p4_halt", 60);
    check("p4_pc", 32'(pc), 32'd3);
`ifdef BIP_BRANCH_EN
    check("p4_acc", 32'(acc), 32'd0);
    check("p4_retired", 32'(retired), 32'd8);
`else
    check("p4_acc", 32'(acc), 32'd2);
    check("p4_retired", 32'(retired), 32'd4);
`endif

    // Program 5: reset during EXEC of STO 9 must suppress the write
    prog_clear({OP_HLT, 11'd0});
    emit(OP_LDI, 11'h055);
    emit(OP_STO, 11'd9);
    emit(OP_LDI, 11'h123);
    for (int i = 0; i < 4; i++) begin
      emit(OP_STO, 11'd0);
      emit(OP_ADD, 11'd0);
    end
    emit(OP_ADDI, 11'd4);
    emit(OP_STO, 11'd9);
    emit(OP_HLT, 11'd0);
    do_reset();
    step(24);
    check("p5_acc_before", 32'(acc), 32'h1234);
    check("p5_pc_before", 32'(pc), 32'd12);
    step(1);
    reset = 1'b1;
    step(1);
    check("p5_rst_acc", 32'(acc), 32'd0);
    check("p5_rst_pc", 32'(pc), 32'd0);
    check("p5_rst_retired", 32'(retired), 32'd0);
    check("p5_rst_halted", 32'(halted), 32'd0);
    prog_clear({OP_HLT, 11'd0});
    emit(OP_LD, 11'd9);
    emit(OP_HLT, 11'd0);
    @(negedge clk) reset = 1'b0;
    step(2);
    check("p5_mem9_unwritten", 32'(acc), 32'h0055);
    run_to_halt("p5_halt", 10);
    check("p5_retired", 32'(retired), 32'd2);

    // Saturation: preload retired near its limit, then keep executing
    prog_clear({OP_NOP, 11'd0});
`ifdef BIP_BRANCH_EN
    rom[0] = {OP_JMP, 11'd0};
`endif
    do_reset();
    @(negedge clk) force dut.retired = 16'hFFFD;
    @(negedge clk) release dut.retired;
    step(20);
    check("sat_retired", 32'(retired), 32'hFFFF);
    check("sat_halted", 32'(halted), 32'd0);
`ifdef BIP_BRANCH_EN
    check("sat_pc_loop", 32'(pc), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
